// File: rtl/branch_resolve.sv
// Carries BTB predictions F->D->E, resolves them in EX, reports mispredicts combinationally, updates BTB one cycle later.
// Never stalls: a redirect is reported every miss cycle and all pipeline holds come from the StallX/FlushX inputs.
module branch_resolve #(
  parameter int         CNT_W = 32,
  parameter logic [6:0] BR_OP = 7'b1100011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             PredictedF,
  input  logic [31:0]      PredictedPCF,
  input  logic [31:0]      PCE,
  input  logic [6:0]       OpcodeE,
  input  logic             BranchE,
  input  logic [31:0]      BrNPC,
  output logic             PredMissE,
  output logic [31:0]      CorrectPC,
  output logic             BtbWr,
  output logic [31:0]      BtbWrPC,
  output logic [31:0]      BtbWrTarget,
  output logic             BtbWrValid,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MissCount
);

  logic        instVD, predVD;
  logic [31:0] predPCD;
  logic        instVE, predVE;
  logic [31:0] predPCE;

  logic        resolveE, isBrE;
  logic        wrValidE;
  logic [31:0] wrTargetE;
  logic        btbWrQ;

  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      instVD  <= 1'b0;
      predVD  <= 1'b0;
      predPCD <= '0;
    end else if (!StallD) begin
      instVD  <= 1'b1;
      predVD  <= PredictedF;
      predPCD <= PredictedPCF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      instVE  <= 1'b0;
      predVE  <= 1'b0;
      predPCE <= '0;
    end else if (!StallE) begin
      instVE  <= instVD;
      predVE  <= predVD;
      predPCE <= predPCD;
    end
  end

  // A stalled instruction resolves only on the cycle it is released.
  assign resolveE = instVE & ~StallE & ~rst;
  assign isBrE    = (OpcodeE == BR_OP);

  always_comb begin
    PredMissE = 1'b0;
    CorrectPC = '0;
    wrValidE  = 1'b0;
    wrTargetE = '0;
    if (resolveE) begin
      if (isBrE) begin
        if (BranchE) begin
          if (!predVE || (predPCE != BrNPC)) begin
            PredMissE = 1'b1;
            CorrectPC = BrNPC;
            wrValidE  = 1'b1;
            wrTargetE = BrNPC;
          end
        end else if (predVE) begin
          PredMissE = 1'b1;
          CorrectPC = PCE + 32'd4;
        end
      end else if (predVE) begin
        // BTB aliased a non-branch: drop the stale entry and fall through.
        PredMissE = 1'b1;
        CorrectPC = PCE + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btbWrQ      <= 1'b0;
      BtbWrPC     <= '0;
      BtbWrTarget <= '0;
      BtbWrValid  <= 1'b0;
    end else begin
      btbWrQ      <= PredMissE;
      BtbWrPC     <= PredMissE ? PCE : '0;
      BtbWrTarget <= wrTargetE;
      BtbWrValid  <= wrValidE;
    end
  end

  // A write due in a reset cycle is dropped rather than issued.
  assign BtbWr = btbWrQ & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else if (resolveE) begin
      if (isBrE && (BranchCount != {CNT_W{1'b1}}))
        BranchCount <= BranchCount + 1'b1;
      if (PredMissE && (MissCount != {CNT_W{1'b1}}))
        MissCount <= MissCount + 1'b1;
    end
  end

endmodule
